// File: rtl/l1_mem_arbiter_pkg.sv
// Shared widths and encodings for the L1 main-memory arbiter: FSM states,
// grant codes and requester identities used by the arbiter, its picker and the caches.
package l1_mem_arbiter_pkg;

  localparam int BLOCK_ADDR_W = 27;
  localparam int BLOCK_W      = 128;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_I    = 2'b01,
    GRANT_D    = 2'b10
  } grant_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

endpackage

// File: rtl/l1_mem_arbiter_if.sv
// Bundle of the icache, dcache and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the caches + memory side.
interface l1_mem_arbiter_if;
  import l1_mem_arbiter_pkg::*;

  logic                    i_memRen;
  logic [BLOCK_ADDR_W-1:0] i_BlockAddr;
  logic                    i_memReadReady;
  logic [BLOCK_W-1:0]      i_memIout;

  logic                    d_memRen;
  logic                    d_memWen;
  logic [BLOCK_ADDR_W-1:0] d_BlockAddr;
  logic [BLOCK_W-1:0]      d_memDin;
  logic                    d_memReady;
  logic [BLOCK_W-1:0]      d_memDout;

  logic                    mem_ren;
  logic                    mem_wen;
  logic [BLOCK_ADDR_W-1:0] mem_addr;
  logic [BLOCK_W-1:0]      mem_din;
  logic [BLOCK_W-1:0]      mem_dout;
  logic                    mem_ready;

  logic [1:0]              grant;

  modport slave (
    input  i_memRen, i_BlockAddr, d_memRen, d_memWen, d_BlockAddr, d_memDin,
           mem_dout, mem_ready,
    output i_memReadReady, i_memIout, d_memReady, d_memDout,
           mem_ren, mem_wen, mem_addr, mem_din, grant
  );

  modport master (
    output i_memRen, i_BlockAddr, d_memRen, d_memWen, d_BlockAddr, d_memDin,
           mem_dout, mem_ready,
    input  i_memReadReady, i_memIout, d_memReady, d_memDout,
           mem_ren, mem_wen, mem_addr, mem_din, grant
  );

endinterface

// File: rtl/l1_mem_arbiter_arb_pick.sv
// Combinational winner select between icache and dcache requests.
// ARB_ROUND_ROBIN_EN: alternate on contention using the last-served owner; else dcache first.
module arb_pick
  import l1_mem_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e last_served,
`endif
  output logic   valid,
  output owner_e winner
);

  always_comb begin
    valid  = i_req | d_req;
    winner = d_req ? OWNER_D : OWNER_I;
`ifdef ARB_ROUND_ROBIN_EN
    // On contention the requester that was not served last goes first.
    if (i_req && d_req) begin
      winner = (last_served == OWNER_I) ? OWNER_D : OWNER_I;
    end
`endif
  end

endmodule

// File: rtl/l1_mem_arbiter.sv
// Grants the single main-memory block port to one L1 cache controller at a time.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed dcache priority.
module l1_mem_arbiter
  import l1_mem_arbiter_pkg::*;
(
  input  logic clock,
  input  logic reset,
  l1_mem_arbiter_if.slave bus
);

  arb_state_e              state_q, state_d;
  grant_e                  grant_q, grant_d;
  logic                    mem_ren_q, mem_ren_d;
  logic                    mem_wen_q, mem_wen_d;
  logic [BLOCK_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0]      mem_din_q, mem_din_d;
  logic                    i_ready, d_ready;
  logic                    pick_valid;
  owner_e                  pick_owner;
  logic                    d_req;
  logic                    d_owner_req;

  assign d_req       = bus.d_memRen | bus.d_memWen;
  // The dcache owns the port through whichever request kind was granted.
  assign d_owner_req = mem_wen_q ? bus.d_memWen : bus.d_memRen;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;

  arb_pick u_pick (
    .i_req       (bus.i_memRen),
    .d_req       (d_req),
    .last_served (last_q),
    .valid       (pick_valid),
    .winner      (pick_owner)
  );
`else
  arb_pick u_pick (
    .i_req  (bus.i_memRen),
    .d_req  (d_req),
    .valid  (pick_valid),
    .winner (pick_owner)
  );
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    grant_d    = grant_q;
    mem_ren_d  = mem_ren_q;
    mem_wen_d  = mem_wen_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
          last_d = pick_owner;
`endif
          if (pick_owner == OWNER_D) begin
            grant_d    = GRANT_D;
            mem_addr_d = bus.d_BlockAddr;
            mem_din_d  = bus.d_memDin;
            mem_wen_d  = bus.d_memWen;
            mem_ren_d  = ~bus.d_memWen;
            state_d    = ARB_SERVE_D;
          end else begin
            grant_d    = GRANT_I;
            mem_addr_d = bus.i_BlockAddr;
            mem_din_d  = '0;
            mem_wen_d  = 1'b0;
            mem_ren_d  = 1'b1;
            state_d    = ARB_SERVE_I;
          end
        end
      end

      ARB_SERVE_I: begin
        if (!bus.i_memRen) begin
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          grant_d   = GRANT_NONE;
          state_d   = ARB_IDLE;
        end else if (bus.mem_ready) begin
          i_ready   = 1'b1;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          state_d   = ARB_RELEASE;
        end
      end

      ARB_SERVE_D: begin
        if (!d_owner_req) begin
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          grant_d   = GRANT_NONE;
          state_d   = ARB_IDLE;
        end else if (bus.mem_ready) begin
          d_ready   = 1'b1;
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          state_d   = ARB_RELEASE;
        end
      end

      ARB_RELEASE: begin
        grant_d = GRANT_NONE;
        state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments let every register sample the same pre-edge values.
    if (!reset) begin
      state_q    <= ARB_IDLE;
      grant_q    <= GRANT_NONE;
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      mem_ren_q  <= mem_ren_d;
      mem_wen_q  <= mem_wen_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= OWNER_I;
    else        last_q <= last_d;
  end
`endif

  assign bus.mem_ren        = mem_ren_q;
  assign bus.mem_wen        = mem_wen_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_din        = mem_din_q;
  assign bus.grant          = grant_q;
  assign bus.i_memReadReady = i_ready;
  assign bus.d_memReady     = d_ready;
  assign bus.i_memIout      = (grant_q == GRANT_I) ? bus.mem_dout : '0;
  assign bus.d_memDout      = (grant_q == GRANT_D) ? bus.mem_dout : '0;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: expected transactions are queued when
// requests are raised and popped when the memory strobe and ready pulse appear.
module tb_l1_mem_arbiter;
  import l1_mem_arbiter_pkg::*;

  typedef struct {
    logic [1:0]              grant;
    bit                      wr;
    logic [BLOCK_ADDR_W-1:0] addr;
    logic [BLOCK_W-1:0]      data;
  } exp_t;

  logic clock;
  logic reset;
  l1_mem_arbiter_if bus ();

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  bit   tb_last_d = 1'b0;
  exp_t sb_q[$];

  l1_mem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [BLOCK_W-1:0] rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Waits for the memory strobe, pops the expected transaction, holds for
  // 'delay' cycles, pulses mem_ready, then drops the owner's request in RELEASE.
  task automatic run_txn(input int delay, output int wait_cyc);
    exp_t e;
    bit   seen;
    seen     = 1'b0;
    wait_cyc = 0;
    @(negedge clock);
    while (!seen && wait_cyc < 20) begin
      if (bus.mem_ren || bus.mem_wen) seen = 1'b1;
      else begin
        tick();
        @(negedge clock);
        wait_cyc++;
      end
    end
    total_cnt++;
    if (!seen || sb_q.size() == 0) begin
      $display("FAIL txn_start: strobe seen=%0d queued=%0d required seen=1 queued>0", seen, sb_q.size());
      if (sb_q.size() > 0) e = sb_q.pop_front();
      return;
    end
    pass_cnt++;
    e = sb_q.pop_front();

    total_cnt++;
    if ({bus.grant, bus.mem_wen, bus.mem_ren, bus.mem_addr} !== {e.grant, e.wr, !e.wr, e.addr})
      $display("FAIL txn_issue: grant=%b wen=%b ren=%b addr=%h required grant=%b wen=%b ren=%b addr=%h",
               bus.grant, bus.mem_wen, bus.mem_ren, bus.mem_addr, e.grant, e.wr, !e.wr, e.addr);
    else pass_cnt++;
    if (e.wr) begin
      total_cnt++;
      if (bus.mem_din !== e.data)
        $display("FAIL txn_wdata: mem_din=%h required %h", bus.mem_din, e.data);
      else pass_cnt++;
    end

    for (int k = 0; k < delay; k++) begin
      tick();
      if (k == delay - 1) begin
        bus.mem_ready = 1'b1;
        bus.mem_dout  = e.wr ? {4{32'h0BADF00D}} : e.data;
      end
      @(negedge clock);
      total_cnt++;
      if ({bus.grant, bus.mem_wen, bus.mem_ren, bus.mem_addr} !== {e.grant, e.wr, !e.wr, e.addr})
        $display("FAIL txn_hold: cycle %0d grant=%b wen=%b ren=%b addr=%h", k,
                 bus.grant, bus.mem_wen, bus.mem_ren, bus.mem_addr);
      else pass_cnt++;
      if (k < delay - 1) begin
        total_cnt++;
        if ({bus.i_memReadReady, bus.d_memReady} !== 2'b00)
          $display("FAIL txn_early_ready: ready i/d=%b%b required 00", bus.i_memReadReady, bus.d_memReady);
        else pass_cnt++;
      end
    end

    total_cnt++;
    if ({bus.i_memReadReady, bus.d_memReady} !== ((e.grant == GRANT_I) ? 2'b10 : 2'b01))
      $display("FAIL txn_ready_route: ready i/d=%b%b for grant %b", bus.i_memReadReady, bus.d_memReady, e.grant);
    else pass_cnt++;
    total_cnt++;
    if (e.grant == GRANT_I) begin
      if (bus.i_memIout !== e.data || bus.d_memDout !== '0)
        $display("FAIL txn_rdata_i: i_memIout=%h d_memDout=%h required %h / 0", bus.i_memIout, bus.d_memDout, e.data);
      else pass_cnt++;
    end else begin
      if ((!e.wr && bus.d_memDout !== e.data) || bus.i_memIout !== '0)
        $display("FAIL txn_rdata_d: d_memDout=%h i_memIout=%h required %h / 0", bus.d_memDout, bus.i_memIout, e.data);
      else pass_cnt++;
    end

    tick();
    bus.mem_ready = 1'b0;
    if (e.grant == GRANT_I) bus.i_memRen = 1'b0;
    else if (e.wr)          bus.d_memWen = 1'b0;
    else                    bus.d_memRen = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({bus.mem_ren, bus.mem_wen, bus.i_memReadReady, bus.d_memReady, bus.grant} !== {4'b0000, e.grant})
      $display("FAIL txn_release: ren=%b wen=%b rdy=%b%b grant=%b required 0 0 00 %b",
               bus.mem_ren, bus.mem_wen, bus.i_memReadReady, bus.d_memReady, bus.grant, e.grant);
    else pass_cnt++;
    tb_last_d = (e.grant == GRANT_D);
  endtask

  task automatic test_reset();
    logic [416:0] obs;
    @(negedge clock);
    obs = {bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_din, bus.grant,
           bus.i_memReadReady, bus.d_memReady, bus.i_memIout, bus.d_memDout};
    total_cnt++;
    if (obs !== '0) $display("FAIL reset_outputs: outputs=%h required 0", obs);
    else pass_cnt++;
    bus.i_memRen = 1'b1;
    bus.d_memWen = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    obs = {bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_din, bus.grant,
           bus.i_memReadReady, bus.d_memReady, bus.i_memIout, bus.d_memDout};
    total_cnt++;
    if (obs !== '0) $display("FAIL reset_held_with_requests: outputs=%h required 0", obs);
    else pass_cnt++;
    bus.i_memRen = 1'b0;
    bus.d_memWen = 1'b0;
    tick();
    reset         = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_dout  = '0;
  endtask

  task automatic test_icache_read();
    int   w;
    exp_t e;
    tick();
    bus.i_memRen    = 1'b1;
    bus.i_BlockAddr = 27'h0000123;
    e.grant = GRANT_I; e.wr = 1'b0; e.addr = 27'h0000123; e.data = {16{8'hA5}};
    sb_q.push_back(e);
    run_txn(5, w);
    total_cnt++;
    if (w !== 1) $display("FAIL icache_latency: strobe after %0d cycles required 1", w);
    else pass_cnt++;
    tick();
    @(negedge clock);
    total_cnt++;
    if ({bus.grant, bus.mem_ren, bus.mem_wen} !== 4'b0000)
      $display("FAIL icache_grant_return: grant=%b ren=%b wen=%b required 00 0 0", bus.grant, bus.mem_ren, bus.mem_wen);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int   w;
    bit   d_wins;
    exp_t e;
    localparam logic [BLOCK_ADDR_W-1:0] IA = 27'h0011AA0;
    localparam logic [BLOCK_ADDR_W-1:0] DA = 27'h0022BB0;
    tick();
    bus.i_memRen    = 1'b1; bus.i_BlockAddr = IA;
    bus.d_memRen    = 1'b1; bus.d_BlockAddr = DA;
    for (int rep = 0; rep < 4; rep++) begin
`ifdef ARB_ROUND_ROBIN_EN
      d_wins = !tb_last_d;
`else
      d_wins = 1'b1;
`endif
      e.grant = d_wins ? GRANT_D : GRANT_I;
      e.wr    = 1'b0;
      e.addr  = d_wins ? DA : IA;
      e.data  = rnd_block();
      sb_q.push_back(e);
      run_txn(2 + rep, w);
      total_cnt++;
      if (w !== 1) $display("FAIL contention_gap: rep %0d strobe after %0d cycles required 1", rep, w);
      else pass_cnt++;
      if (rep < 3) begin
        tick();
        if (tb_last_d) bus.d_memRen = 1'b1;
        else           bus.i_memRen = 1'b1;
      end
    end
    e.grant = bus.i_memRen ? GRANT_I : GRANT_D;
    e.wr    = 1'b0;
    e.addr  = bus.i_memRen ? IA : DA;
    e.data  = rnd_block();
    sb_q.push_back(e);
    run_txn(1, w);
    total_cnt++;
    if (w !== 1) $display("FAIL contention_follow_up: strobe after %0d cycles required 1", w);
    else pass_cnt++;
  endtask

  task automatic test_dcache_write();
    int   w;
    exp_t e;
    tick();
    bus.d_memWen    = 1'b1;
    bus.d_BlockAddr = 27'h00007FF;
    bus.d_memDin    = {4{32'hDEADBEEF}};
    e.grant = GRANT_D; e.wr = 1'b1; e.addr = 27'h00007FF; e.data = {4{32'hDEADBEEF}};
    sb_q.push_back(e);
    run_txn(4, w);
    total_cnt++;
    if (w !== 1) $display("FAIL write_latency: strobe after %0d cycles required 1", w);
    else pass_cnt++;
    tick();
    @(negedge clock);
    total_cnt++;
    if ({bus.d_memReady, bus.mem_ren, bus.mem_wen, bus.grant} !== 5'b0)
      $display("FAIL write_single_pulse: ready=%b ren=%b wen=%b grant=%b required 0 0 0 00",
               bus.d_memReady, bus.mem_ren, bus.mem_wen, bus.grant);
    else pass_cnt++;
  endtask

  task automatic test_write_then_read();
    int   w;
    exp_t e;
    tick();
    bus.d_memWen    = 1'b1;
    bus.d_memRen    = 1'b1;
    bus.d_BlockAddr = 27'h03C3C3C;
    bus.d_memDin    = rnd_block();
    e.grant = GRANT_D; e.wr = 1'b1; e.addr = 27'h03C3C3C; e.data = bus.d_memDin;
    sb_q.push_back(e);
    e.wr = 1'b0; e.data = rnd_block();
    sb_q.push_back(e);
    run_txn(3, w);
    total_cnt++;
    if (w !== 1) $display("FAIL wr_rd_first: strobe after %0d cycles required 1", w);
    else pass_cnt++;
    run_txn(2, w);
    total_cnt++;
    if (w !== 1) $display("FAIL wr_rd_second: strobe after %0d cycles required 1", w);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    tick();
    bus.d_memRen    = 1'b1;
    bus.d_BlockAddr = 27'h00ABCDE;
    @(negedge clock);
    tick();
    @(negedge clock);
    total_cnt++;
    if ({bus.grant, bus.mem_ren} !== 3'b101)
      $display("FAIL abort_grant: grant=%b ren=%b required 10 1", bus.grant, bus.mem_ren);
    else pass_cnt++;
    tick();
    bus.d_memRen = 1'b0;
    @(negedge clock);
    total_cnt++;
    if (bus.d_memReady !== 1'b0) $display("FAIL abort_no_pulse: d_memReady=%b required 0", bus.d_memReady);
    else pass_cnt++;
    tick();
    @(negedge clock);
    total_cnt++;
    if ({bus.mem_ren, bus.mem_wen, bus.grant} !== 4'b0000)
      $display("FAIL abort_idle: ren=%b wen=%b grant=%b required 0 0 00", bus.mem_ren, bus.mem_wen, bus.grant);
    else pass_cnt++;
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_dout  = {16{8'hA5}};
    @(negedge clock);
    total_cnt++;
    if ({bus.i_memReadReady, bus.d_memReady, bus.i_memIout, bus.d_memDout} !== '0)
      $display("FAIL stray_ready: rdy=%b%b i_dout=%h d_dout=%h required all 0",
               bus.i_memReadReady, bus.d_memReady, bus.i_memIout, bus.d_memDout);
    else pass_cnt++;
    tick();
    bus.mem_ready = 1'b0;
    tb_last_d     = 1'b1;
  endtask

  task automatic test_reset_mid_txn();
    int           w;
    exp_t         e;
    logic [416:0] obs;
    tick();
    bus.d_memWen    = 1'b1;
    bus.d_BlockAddr = 27'h0000055;
    bus.d_memDin    = {4{32'h13579BDF}};
    @(negedge clock);
    tick();
    @(negedge clock);
    total_cnt++;
    if ({bus.grant, bus.mem_wen} !== 3'b101)
      $display("FAIL midreset_serving: grant=%b wen=%b required 10 1", bus.grant, bus.mem_wen);
    else pass_cnt++;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    obs = {bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_din, bus.grant,
           bus.i_memReadReady, bus.d_memReady, bus.i_memIout, bus.d_memDout};
    total_cnt++;
    if (obs !== '0) $display("FAIL midreset_outputs: outputs=%h required 0", obs);
    else pass_cnt++;
    tick();
    reset        = 1'b1;
    bus.d_memWen = 1'b0;
    tb_last_d    = 1'b0;
    tick();
    bus.i_memRen    = 1'b1;
    bus.i_BlockAddr = 27'h01F00F0;
    e.grant = GRANT_I; e.wr = 1'b0; e.addr = 27'h01F00F0; e.data = rnd_block();
    sb_q.push_back(e);
    run_txn(2, w);
    total_cnt++;
    if (w !== 1) $display("FAIL midreset_regrant: strobe after %0d cycles required 1", w);
    else pass_cnt++;
  endtask

  initial begin
    reset           = 1'b0;
    bus.i_memRen    = 1'b0;
    bus.i_BlockAddr = '0;
    bus.d_memRen    = 1'b0;
    bus.d_memWen    = 1'b0;
    bus.d_BlockAddr = '0;
    bus.d_memDin    = '0;
    bus.mem_ready   = 1'b1;
    bus.mem_dout    = '1;

    test_reset();
    test_icache_read();
    test_simultaneous();
    test_dcache_write();
    test_write_then_read();
    test_abort();
    test_reset_mid_txn();

    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left required 0", sb_q.size());
    else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
